// File: rtl/csr_if.sv
// CSR access, trap and interrupt signals between the pipeline (master) and the
// machine-mode CSR unit (slave). HPM_W must equal max(NB_HPM,1) of the unit.
interface csr_if #(
    parameter int HPM_W = 2
);
    logic [11:0]      CSR_RADR_SD;
    logic [31:0]      CSR_RDATA_SC;
    logic             CSR_ILLEGAL_SC;
    logic             CSR_ENABLE_SM;
    logic [1:0]       CSR_OP_SM;
    logic [11:0]      CSR_WADR_SM;
    logic [31:0]      CSR_WDATA_SM;
    logic             EXCEPTION_SM;
    logic             MRET_SM;
    logic [31:0]      MEPC_WDATA_SM;
    logic [31:0]      MCAUSE_WDATA_SM;
    logic [31:0]      MTVAL_WDATA_SM;
    logic             INSTR_RETIRED_SM;
    logic [HPM_W-1:0] HPM_EVENT_SM;
    logic             MEIP_IN;
    logic             MTIP_IN;
    logic             MSIP_IN;
    logic [31:0]      MEPC_SC;
    logic [31:0]      MSTATUS_RC;
    logic [31:0]      MTVEC_VALUE_RC;
    logic [31:0]      MIE_VALUE_RC;
    logic [31:0]      MIP_VALUE_RC;
    logic [31:0]      MCAUSE_SC;
    logic             IRQ_PENDING_RC;
    logic [31:0]      IRQ_CAUSE_RC;
    logic [31:0]      TRAP_TARGET_RC;

    modport master (
        output CSR_RADR_SD, CSR_ENABLE_SM, CSR_OP_SM, CSR_WADR_SM, CSR_WDATA_SM,
               EXCEPTION_SM, MRET_SM, MEPC_WDATA_SM, MCAUSE_WDATA_SM, MTVAL_WDATA_SM,
               INSTR_RETIRED_SM, HPM_EVENT_SM, MEIP_IN, MTIP_IN, MSIP_IN,
        input  CSR_RDATA_SC, CSR_ILLEGAL_SC, MEPC_SC, MSTATUS_RC, MTVEC_VALUE_RC,
               MIE_VALUE_RC, MIP_VALUE_RC, MCAUSE_SC, IRQ_PENDING_RC, IRQ_CAUSE_RC,
               TRAP_TARGET_RC
    );

    modport slave (
        input  CSR_RADR_SD, CSR_ENABLE_SM, CSR_OP_SM, CSR_WADR_SM, CSR_WDATA_SM,
               EXCEPTION_SM, MRET_SM, MEPC_WDATA_SM, MCAUSE_WDATA_SM, MTVAL_WDATA_SM,
               INSTR_RETIRED_SM, HPM_EVENT_SM, MEIP_IN, MTIP_IN, MSIP_IN,
        output CSR_RDATA_SC, CSR_ILLEGAL_SC, MEPC_SC, MSTATUS_RC, MTVEC_VALUE_RC,
               MIE_VALUE_RC, MIP_VALUE_RC, MCAUSE_SC, IRQ_PENDING_RC, IRQ_CAUSE_RC,
               TRAP_TARGET_RC
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: status/trap registers, interrupt selection and
// mcycle/minstret/mhpm counters with inhibit control.
module csr_unit #(
    parameter int          NB_HPM     = 2,
    parameter int          CNT_W      = 64,
    parameter logic [31:0] MISA_VALUE = 32'h40100100,
    parameter int          VEC_EN     = 1
) (
    input  logic  clk,
    input  logic  reset_n,
    csr_if.slave  bus
);
    localparam int          NB_CNT       = NB_HPM + 2;
    localparam int          HI_W         = CNT_W - 32;
    localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'h1 << NB_HPM) - 32'h1) << 3);

    logic        armed_reg;
    logic        mie_bit_reg, mpie_bit_reg;
    logic [2:0]  mie_en_reg;            // {MEIE, MTIE, MSIE}
    logic [2:0]  mip_reg;               // {MEIP, MTIP, MSIP}
    logic [29:0] mtvec_base_reg;
    logic        mtvec_mode_reg;
    logic [29:0] mepc_reg;
    logic [31:0] mscratch_reg, mcause_reg, mtval_reg, minhibit_reg;
    logic [CNT_W-1:0] cnt_val [NB_CNT];

    logic [31:0] mstatus_val, mie_val, mip_val, mtvec_val, mepc_val;
    logic [32:0] rd_view, wr_view;
    logic [31:0] wval;
    logic        wr_en;

    assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_bit_reg, 3'b0, mie_bit_reg, 3'b0};
    assign mie_val     = {20'b0, mie_en_reg[2], 3'b0, mie_en_reg[1], 3'b0, mie_en_reg[0], 3'b0};
    assign mip_val     = {20'b0, mip_reg[2], 3'b0, mip_reg[1], 3'b0, mip_reg[0], 3'b0};
    assign mtvec_val   = {mtvec_base_reg, 1'b0, mtvec_mode_reg};
    assign mepc_val    = {mepc_reg, 2'b00};

    // Counter k lives at address offset 0 (mcycle), 2 (minstret) or k+1 (mhpm);
    // the same offset is its mcountinhibit bit.
    function automatic logic [11:0] cnt_off(input int k);
        return (k == 0) ? 12'd0 : 12'(k + 1);
    endfunction

    // Returns {illegal, data} for an address.
    function automatic logic [32:0] csr_read(input logic [11:0] adr);
        logic [32:0] r;
        logic [63:0] ext;
        r = {1'b1, 32'h0};
        case (adr)
            12'h300: r = {1'b0, mstatus_val};
            12'h301: r = {1'b0, MISA_VALUE};
            12'h304: r = {1'b0, mie_val};
            12'h305: r = {1'b0, mtvec_val};
            12'h310: r = {1'b0, 32'h0};
            12'h320: r = {1'b0, minhibit_reg};
            12'h340: r = {1'b0, mscratch_reg};
            12'h341: r = {1'b0, mepc_val};
            12'h342: r = {1'b0, mcause_reg};
            12'h343: r = {1'b0, mtval_reg};
            12'h344: r = {1'b0, mip_val};
            default: begin
                for (int k = 0; k < NB_CNT; k++) begin
                    ext = 64'(cnt_val[k]);
                    if (adr == 12'hB00 + cnt_off(k)) r = {1'b0, ext[31:0]};
                    if (adr == 12'hB80 + cnt_off(k)) r = {1'b0, ext[63:32]};
                end
            end
        endcase
        return r;
    endfunction

    always_comb begin
        rd_view = csr_read(bus.CSR_RADR_SD);
        wr_view = csr_read(bus.CSR_WADR_SM);
        case (bus.CSR_OP_SM)
            2'b01:   wval = bus.CSR_WDATA_SM;
            2'b10:   wval = wr_view[31:0] | bus.CSR_WDATA_SM;
            2'b11:   wval = wr_view[31:0] & ~bus.CSR_WDATA_SM;
            default: wval = wr_view[31:0];
        endcase
    end

    assign bus.CSR_RDATA_SC   = rd_view[31:0];
    assign bus.CSR_ILLEGAL_SC = rd_view[32];
    assign wr_en = armed_reg && bus.CSR_ENABLE_SM && (bus.CSR_OP_SM != 2'b00) &&
                   !bus.EXCEPTION_SM && !bus.MRET_SM && (bus.CSR_WADR_SM[11:10] != 2'b11);

    // armed_reg swallows the first edge after reset release so stale inputs are not applied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_reg      <= 1'b0;
            mie_bit_reg    <= 1'b0;
            mpie_bit_reg   <= 1'b0;
            mie_en_reg     <= '0;
            mip_reg        <= '0;
            mtvec_base_reg <= '0;
            mtvec_mode_reg <= 1'b0;
            mepc_reg       <= '0;
            mscratch_reg   <= '0;
            mcause_reg     <= '0;
            mtval_reg      <= '0;
            minhibit_reg   <= '0;
        end else if (!armed_reg) begin
            armed_reg <= 1'b1;
        end else begin
            mip_reg <= {bus.MEIP_IN, bus.MTIP_IN, bus.MSIP_IN};
            if (bus.EXCEPTION_SM) begin
                mepc_reg     <= bus.MEPC_WDATA_SM[31:2];
                mcause_reg   <= bus.MCAUSE_WDATA_SM;
                mtval_reg    <= bus.MTVAL_WDATA_SM;
                mpie_bit_reg <= mie_bit_reg;
                mie_bit_reg  <= 1'b0;
            end else if (bus.MRET_SM) begin
                mie_bit_reg  <= mpie_bit_reg;
                mpie_bit_reg <= 1'b1;
            end else if (wr_en) begin
                case (bus.CSR_WADR_SM)
                    12'h300: begin
                        mie_bit_reg  <= wval[3];
                        mpie_bit_reg <= wval[7];
                    end
                    12'h304: mie_en_reg <= {wval[11], wval[7], wval[3]};
                    12'h305: begin
                        mtvec_base_reg <= wval[31:2];
                        mtvec_mode_reg <= (VEC_EN != 0) && wval[0];
                    end
                    12'h320: minhibit_reg <= wval & INHIBIT_MASK;
                    12'h340: mscratch_reg <= wval;
                    12'h341: mepc_reg     <= wval[31:2];
                    12'h342: mcause_reg   <= wval;
                    12'h343: mtval_reg    <= wval;
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB_CNT; gi++) begin : g_cnt
            localparam logic [11:0] OFF = (gi == 0) ? 12'd0 : 12'(gi + 1);
            logic [CNT_W-1:0] cnt_reg;
            logic ev, wr_lo, wr_hi;
            if (gi == 0) begin : g_ev
                assign ev = 1'b1;
            end else if (gi == 1) begin : g_ev
                assign ev = bus.INSTR_RETIRED_SM;
            end else begin : g_ev
                assign ev = bus.HPM_EVENT_SM[gi-2];
            end
            assign wr_lo = wr_en && (bus.CSR_WADR_SM == 12'hB00 + OFF);
            assign wr_hi = wr_en && (bus.CSR_WADR_SM == 12'hB80 + OFF);
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (armed_reg) begin
                    if (wr_lo)
                        cnt_reg[31:0] <= wval;
                    else if (wr_hi)
                        cnt_reg[CNT_W-1:32] <= wval[HI_W-1:0];
                    else if (ev && !minhibit_reg[OFF[4:0]])
                        cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    logic [2:0]  pend;
    logic        irq;
    logic [3:0]  code;
    assign pend = mip_reg & mie_en_reg;
    assign irq  = mie_bit_reg && (|pend);

    always_comb begin
        if (pend[2])      code = 4'd11;
        else if (pend[0]) code = 4'd3;
        else if (pend[1]) code = 4'd7;
        else              code = 4'd0;
    end

    assign bus.IRQ_PENDING_RC = irq;
    assign bus.IRQ_CAUSE_RC   = irq ? {1'b1, 27'b0, code} : 32'h0;
    assign bus.TRAP_TARGET_RC = (mtvec_mode_reg && irq) ?
                                {mtvec_base_reg, 2'b00} + {26'b0, code, 2'b00} :
                                {mtvec_base_reg, 2'b00};
    assign bus.MEPC_SC        = mepc_val;
    assign bus.MSTATUS_RC     = mstatus_val;
    assign bus.MTVEC_VALUE_RC = mtvec_val;
    assign bus.MIE_VALUE_RC   = mie_val;
    assign bus.MIP_VALUE_RC   = mip_val;
    assign bus.MCAUSE_SC      = mcause_reg;
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: CSR ops/masks, traps, counters, interrupts, illegal access.
module tb_csr_unit;
    localparam int          NB_HPM = 2;
    localparam logic [31:0] MISA   = 32'h40100100;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    csr_if #(.HPM_W(NB_HPM)) bus ();

    csr_unit #(
        .NB_HPM(NB_HPM), .CNT_W(64), .MISA_VALUE(MISA), .VEC_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] adr, input logic [31:0] exp);
        bus.CSR_RADR_SD = adr;
        #1;
        check_eq(tag, bus.CSR_RDATA_SC, exp);
    endtask

    task automatic csr_write(input logic [11:0] adr, input logic [1:0] op, input logic [31:0] data);
        bus.CSR_ENABLE_SM = 1'b1;
        bus.CSR_WADR_SM   = adr;
        bus.CSR_OP_SM     = op;
        bus.CSR_WDATA_SM  = data;
        tick();
        bus.CSR_ENABLE_SM = 1'b0;
        bus.CSR_OP_SM     = 2'b00;
        $display("[TB] csr wr adr=0x%03h op=%0d data=0x%08h", adr, op, data);
    endtask

    task automatic trap(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] tval);
        bus.EXCEPTION_SM    = 1'b1;
        bus.MEPC_WDATA_SM   = epc;
        bus.MCAUSE_WDATA_SM = cause;
        bus.MTVAL_WDATA_SM  = tval;
        tick();
        bus.EXCEPTION_SM    = 1'b0;
        $display("[TB] exception epc=0x%08h cause=0x%08h tval=0x%08h", epc, cause, tval);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        bus.CSR_RADR_SD      = 12'h300;
        bus.CSR_ENABLE_SM    = 1'b0;
        bus.CSR_OP_SM        = 2'b00;
        bus.CSR_WADR_SM      = 12'h0;
        bus.CSR_WDATA_SM     = 32'h0;
        bus.EXCEPTION_SM     = 1'b0;
        bus.MRET_SM          = 1'b0;
        bus.MEPC_WDATA_SM    = 32'h0;
        bus.MCAUSE_WDATA_SM  = 32'h0;
        bus.MTVAL_WDATA_SM   = 32'h0;
        bus.INSTR_RETIRED_SM = 1'b0;
        bus.HPM_EVENT_SM     = '0;
        bus.MEIP_IN          = 1'b0;
        bus.MTIP_IN          = 1'b0;
        bus.MSIP_IN          = 1'b0;

        // Reset state, observed while reset is held
        #12;
        chk_rd("rst_mstatus_rd", 12'h300, 32'h00001800);
        check_eq("rst_mstatus", bus.MSTATUS_RC, 32'h00001800);
        chk_rd("rst_misa", 12'h301, MISA);
        chk_rd("rst_mcycle", 12'hB00, 32'h0);
        check_eq("rst_irq", {31'b0, bus.IRQ_PENDING_RC}, 32'h0);
        check_eq("rst_target", bus.TRAP_TARGET_RC, 32'h0);

        // A stale write held across release must not land on the first edge
        bus.CSR_ENABLE_SM = 1'b1;
        bus.CSR_OP_SM     = 2'b01;
        bus.CSR_WADR_SM   = 12'h340;
        bus.CSR_WDATA_SM  = 32'hDEADBEEF;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        bus.CSR_ENABLE_SM = 1'b0;
        bus.CSR_OP_SM     = 2'b00;
        chk_rd("stale_write", 12'h340, 32'h0);

        // mstatus masks and ops
        csr_write(12'h300, 2'b01, 32'hFFFFFFFF);
        chk_rd("mstatus_wr", 12'h300, 32'h00001888);
        csr_write(12'h300, 2'b11, 32'h00000008);
        chk_rd("mstatus_clr", 12'h300, 32'h00001880);
        csr_write(12'h300, 2'b10, 32'h00000008);
        check_eq("mstatus_set", bus.MSTATUS_RC, 32'h00001888);

        // Trap entry and return
        trap(32'h00000103, 32'h2, 32'h55);
        check_eq("exc_mepc", bus.MEPC_SC, 32'h00000100);
        check_eq("exc_mstatus", bus.MSTATUS_RC, 32'h00001880);
        check_eq("exc_mcause", bus.MCAUSE_SC, 32'h2);
        chk_rd("exc_mtval", 12'h343, 32'h55);
        bus.MRET_SM = 1'b1;
        tick();
        bus.MRET_SM = 1'b0;
        $display("[TB] mret");
        check_eq("mret_mstatus", bus.MSTATUS_RC, 32'h00001888);

        // Exception beats a same-cycle CSR write
        bus.CSR_ENABLE_SM = 1'b1;
        bus.CSR_OP_SM     = 2'b01;
        bus.CSR_WADR_SM   = 12'h341;
        bus.CSR_WDATA_SM  = 32'h00000444;
        trap(32'h00000200, 32'h7, 32'h0);
        bus.CSR_ENABLE_SM = 1'b0;
        bus.CSR_OP_SM     = 2'b00;
        check_eq("exc_vs_wr_mepc", bus.MEPC_SC, 32'h00000200);
        check_eq("exc_vs_wr_status", bus.MSTATUS_RC, 32'h00001880);

        // mepc alignment, mscratch ops, no-op
        csr_write(12'h341, 2'b01, 32'h12345677);
        check_eq("mepc_align", bus.MEPC_SC, 32'h12345674);
        csr_write(12'h340, 2'b01, 32'hA5A5A5A5);
        csr_write(12'h340, 2'b10, 32'h0F0F0000);
        chk_rd("mscratch_set", 12'h340, 32'hAFAFA5A5);
        csr_write(12'h340, 2'b11, 32'h000000FF);
        chk_rd("mscratch_clr", 12'h340, 32'hAFAFA500);
        csr_write(12'h340, 2'b00, 32'h0);
        chk_rd("mscratch_nop", 12'h340, 32'hAFAFA500);

        // mcycle carry across halves, write priority over increment, inhibit
        csr_write(12'hB00, 2'b01, 32'hFFFFFFFF);
        chk_rd("mcycle_lo_wr", 12'hB00, 32'hFFFFFFFF);
        csr_write(12'hB80, 2'b01, 32'h0);
        chk_rd("mcycle_hold_lo", 12'hB00, 32'hFFFFFFFF);
        chk_rd("mcycle_hold_hi", 12'hB80, 32'h0);
        tick();
        chk_rd("mcycle_carry_lo", 12'hB00, 32'h0);
        chk_rd("mcycle_carry_hi", 12'hB80, 32'h1);
        csr_write(12'h320, 2'b01, 32'h1);
        chk_rd("mcycle_inh_lo", 12'hB00, 32'h1);
        tick(); tick(); tick();
        chk_rd("mcycle_inh_hold_lo", 12'hB00, 32'h1);
        chk_rd("mcycle_inh_hold_hi", 12'hB80, 32'h1);
        csr_write(12'h320, 2'b01, 32'hFFFFFFFF);
        chk_rd("minhibit_mask", 12'h320, 32'h0000001D);
        csr_write(12'h320, 2'b01, 32'h0);

        // minstret and mhpmcounter3 events
        csr_write(12'hB02, 2'b01, 32'h5);
        chk_rd("minstret_wr", 12'hB02, 32'h5);
        bus.INSTR_RETIRED_SM = 1'b1;
        tick();
        bus.INSTR_RETIRED_SM = 1'b0;
        chk_rd("minstret_inc", 12'hB02, 32'h6);
        csr_write(12'hB03, 2'b01, 32'h0);
        bus.HPM_EVENT_SM = 2'b01;
        tick(); tick();
        bus.HPM_EVENT_SM = 2'b00;
        chk_rd("hpm3_inc", 12'hB03, 32'h2);
        chk_rd("hpm4_idle", 12'hB04, 32'h0);

        // mtvec/mie masks and interrupt selection
        csr_write(12'h305, 2'b01, 32'hFFFFFFFF);
        check_eq("mtvec_mask", bus.MTVEC_VALUE_RC, 32'hFFFFFFFD);
        csr_write(12'h305, 2'b01, 32'h00001001);
        check_eq("mtvec_wr", bus.MTVEC_VALUE_RC, 32'h00001001);
        csr_write(12'h304, 2'b01, 32'hFFFFFFFF);
        check_eq("mie_mask", bus.MIE_VALUE_RC, 32'h00000888);
        csr_write(12'h300, 2'b10, 32'h8);
        bus.MTIP_IN = 1'b1;
        bus.MEIP_IN = 1'b1;
        tick();
        check_eq("irq_pending", {31'b0, bus.IRQ_PENDING_RC}, 32'h1);
        check_eq("mip_value", bus.MIP_VALUE_RC, 32'h00000880);
        check_eq("irq_cause_meip", bus.IRQ_CAUSE_RC, 32'h8000000B);
        check_eq("target_meip", bus.TRAP_TARGET_RC, 32'h0000102C);
        bus.MEIP_IN = 1'b0;
        tick();
        check_eq("irq_cause_mtip", bus.IRQ_CAUSE_RC, 32'h80000007);
        check_eq("target_mtip", bus.TRAP_TARGET_RC, 32'h0000101C);
        bus.MSIP_IN = 1'b1;
        tick();
        check_eq("irq_cause_msip", bus.IRQ_CAUSE_RC, 32'h80000003);
        check_eq("target_msip", bus.TRAP_TARGET_RC, 32'h0000100C);
        bus.MSIP_IN = 1'b0;
        bus.MTIP_IN = 1'b0;
        tick();
        check_eq("irq_none", {31'b0, bus.IRQ_PENDING_RC}, 32'h0);
        check_eq("irq_cause_none", bus.IRQ_CAUSE_RC, 32'h0);
        check_eq("target_base", bus.TRAP_TARGET_RC, 32'h00001000);

        // Unimplemented and read-only addresses
        chk_rd("illegal_data", 12'h7C0, 32'h0);
        check_eq("illegal_flag", {31'b0, bus.CSR_ILLEGAL_SC}, 32'h1);
        bus.CSR_RADR_SD = 12'hB05;
        #1;
        check_eq("illegal_hpm5", {31'b0, bus.CSR_ILLEGAL_SC}, 32'h1);
        chk_rd("legal_mip_data", 12'h344, 32'h0);
        check_eq("legal_mip_flag", {31'b0, bus.CSR_ILLEGAL_SC}, 32'h0);
        csr_write(12'hF11, 2'b01, 32'hFFFFFFFF);
        check_eq("ro_mstatus", bus.MSTATUS_RC, 32'h00001888);
        check_eq("ro_mtvec", bus.MTVEC_VALUE_RC, 32'h00001001);
        chk_rd("ro_mscratch", 12'h340, 32'hAFAFA500);
        csr_write(12'h301, 2'b01, 32'h0);
        chk_rd("misa_ro", 12'h301, MISA);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter NB_HPM, default 2, number of hardware performance counters (0..8).
REQ-002 SHALL have parameter CNT_W, default 64, counter width (33..64).
REQ-003 SHALL have parameter MISA_VALUE, default 32'h40100100, misa read value.
REQ-004 SHALL have parameter VEC_EN, default 1, enables mtvec vectored mode.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports clk and reset_n.
REQ-006 SHALL have these ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- CSR_RADR_SD  in  12  read address
- CSR_RDATA_SC  out  32  read data
- CSR_ILLEGAL_SC  out  1  read address not implemented
- CSR_ENABLE_SM  in  1  CSR write strobe
- CSR_OP_SM  in  2  01 write, 10 set, 11 clear, 00 no-op
- CSR_WADR_SM  in  12  write address
- CSR_WDATA_SM  in  32  operand
- EXCEPTION_SM  in  1  trap entry
- MRET_SM  in  1  trap return
- MEPC_WDATA_SM, MCAUSE_WDATA_SM, MTVAL_WDATA_SM  in  32 each  trap values
- INSTR_RETIRED_SM  in  1  retire pulse
- HPM_EVENT_SM  in  max(NB_HPM,1)  per-counter event
- MEIP_IN, MTIP_IN, MSIP_IN  in  1 each  interrupt lines
- MEPC_SC, MSTATUS_RC, MTVEC_VALUE_RC, MIE_VALUE_RC, MIP_VALUE_RC, MCAUSE_SC  out  32 each  register values
- IRQ_PENDING_RC  out  1  interrupt to take
- IRQ_CAUSE_RC  out  32  mcause for that interrupt
- TRAP_TARGET_RC  out  32  trap PC

Function
REQ-007 SHALL apply a CSR write on the rising edge when CSR_ENABLE_SM=1: new = operand (01), old|operand (10), or old&~operand (11); op 00 changes nothing.
REQ-008 SHALL apply these write masks:
- mstatus: only bits 3 (MIE) and 7 (MPIE) writable; MPP[12:11] hardwired 11; all other bits 0.
- mie: only bits 3, 7 and 11 writable.
- mtvec: bit1 reads 0; bit0 writable only if VEC_EN=1, else 0.
- mepc: bits[1:0] read 0.
- mscratch, mcause, mtval: fully writable.
REQ-009 SHALL ignore writes to read-only addresses (addr[11:10]=11), misa, mstatush, mip and unimplemented addresses.
REQ-010 SHALL register MEIP_IN, MTIP_IN and MSIP_IN through one flop each into mip bits 11, 7 and 3.
REQ-011 SHALL provide combinational reads of current register state, with no write bypass.
REQ-012 SHALL set CSR_ILLEGAL_SC=1 with data 0 for unimplemented read addresses.
REQ-013 SHALL implement these counters, each CNT_W bits:
- mcycle: 0xB00 / 0xB80.
- minstret: 0xB02 / 0xB82.
- mhpmcounter(3+i): 0xB03+i / 0xB83+i, for i<NB_HPM.
- mcountinhibit: 0x320; bits 0, 2 and 3..2+NB_HPM writable.
REQ-014 SHALL read the high-half address as counter[CNT_W-1:32] zero-extended.
REQ-015 SHALL write a half of a counter without changing the other half.
REQ-016 SHALL increment counters each cycle unless inhibited: mcycle always, minstret on INSTR_RETIRED_SM, hpm i on HPM_EVENT_SM[i]; counters wrap from all-ones to 0.
REQ-017 SHALL give a counter write priority over that counter's increment in the same cycle.
REQ-018 SHALL, on EXCEPTION_SM, load mepc=MEPC_WDATA_SM&~3, mcause and mtval, and set MPIE<=MIE, MIE<=0.
REQ-019 SHALL, on MRET_SM, set MIE<=MPIE and MPIE<=1.
REQ-020 SHALL use priority EXCEPTION_SM > MRET_SM > CSR write; lower-priority events in the same cycle are dropped, and counters still increment.
REQ-021 SHALL drive IRQ_PENDING_RC = mstatus.MIE & |(mip & mie).
REQ-022 SHALL select the IRQ cause with priority MEIP(11) > MSIP(3) > MTIP(7), drive IRQ_CAUSE_RC = {1,27'b0,code}, and drive 0 when nothing is pending.
REQ-023 SHALL drive TRAP_TARGET_RC = {mtvec[31:2],00}, or base+4*code when mode=1 and IRQ_PENDING_RC=1.

Reset
REQ-024 SHALL, on reset_n low, immediately and asynchronously clear all registers, counters, mcountinhibit and interrupt sync flops to 0, except mstatus=32'h00001800 and misa=MISA_VALUE.
REQ-025 SHALL hold every output at the value derived from reset state during reset; for example, CSR_RDATA_SC for address 0x300 reads 32'h1800.
REQ-026 SHALL, when reset is asserted mid-operation, abort any pending write; the first edge after release performs no update from stale inputs.

Verification
REQ-027 SHALL cover: write mstatus 0xFFFFFFFF, op 01 -> reads 0x00001888; then clear op with 0x8 -> reads 0x00001880.
REQ-028 SHALL cover: mstatus.MIE=1, then EXCEPTION_SM with MEPC_WDATA_SM=0x103 and mcause 2 -> mepc=0x100, MIE=0, MPIE=1; then MRET_SM -> MIE=1, MPIE=1.
REQ-029 SHALL cover: CNT_W=64, write mcycle low=0xFFFFFFFF and high=0, one idle cycle -> low=0, high=1; with inhibit bit0=1 the value holds.
REQ-030 SHALL cover: mtvec=0x1001, mie=0x888, MIE=1, MTIP_IN and MEIP_IN both raised -> after one cycle IRQ_CAUSE_RC=0x8000000B and TRAP_TARGET_RC=0x102C.
REQ-031 SHALL cover: EXCEPTION_SM and a CSR write to mepc in the same cycle -> trap values win and the write is lost.
REQ-032 SHALL cover: read 0x7C0 -> CSR_ILLEGAL_SC=1 and data 0; write to 0xF11 -> no state change.
